// File: rtl/rgb565_grayscale_multi_ise.sv
// -----------------------------------------------------------------------------
// rgb565_grayscale_multi_ise
//
// Multi-cycle custom-instruction unit. It converts four packed RGB565 pixels
// into four 8-bit grayscale bytes. Two pixels arrive in each operand:
//   valueA = {pixel1, pixel0}, valueB = {pixel3, pixel2}
//   result = {gray3, gray2, gray1, gray0}
//
// The unit accepts an instruction when start=1 and iseId==customId. It then
// spends 4/PIXELS_PER_CYCLE cycles in BUSY, converting PIXELS_PER_CYCLE pixels
// on each edge. After that it shows the bytes for exactly one cycle in DONE.
// result is forced to zero outside DONE, so several ISE results can be
// OR-combined on the CPU side.
//
// Parameters:
//   customId         - instruction ID this unit answers to (default 8'hC)
//   PIXELS_PER_CYCLE - number of converters: 1, 2 or 4 (default 1)
//
// Optional build macro:
//   GRAYSCALE_ROUND_EN - when defined, gray = (S + 128) >> 8 (round to
//                        nearest); otherwise gray = S >> 8 (truncate).
//
// Ports:
//   clock  in   1  system clock, rising edge
//   reset  in   1  asynchronous active-low reset
//   start  in   1  instruction-issue strobe
//   iseId  in   8  custom-instruction ID
//   valueA in  32  pixel1[31:16], pixel0[15:0]
//   valueB in  32  pixel3[31:16], pixel2[15:0]
//   done   out  1  one-cycle completion pulse
//   result out 32  {g3,g2,g1,g0} while done=1, otherwise 0
//   busy   out  1  high while a conversion is in progress
// -----------------------------------------------------------------------------
module rgb565_grayscale_multi_ise #(
  parameter logic [7:0] customId         = 8'hC,
  parameter int         PIXELS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        busy
);

  // Stop elaboration on an unsupported converter count, so that the index
  // arithmetic below can never skip or repeat a pixel.
  if (!(PIXELS_PER_CYCLE == 1 || PIXELS_PER_CYCLE == 2 ||
        PIXELS_PER_CYCLE == 4)) begin : g_bad_pixels_per_cycle
    $error("rgb565_grayscale_multi_ise: PIXELS_PER_CYCLE must be 1, 2 or 4");
  end

  // The pixel index advances by STEP on each edge. LAST_IDX marks the group
  // whose conversion ends the BUSY phase. When PIXELS_PER_CYCLE is 4, both
  // values are 0: one group, and the index never moves.
  localparam logic [1:0] STEP     = 2'(PIXELS_PER_CYCLE);
  localparam logic [1:0] LAST_IDX = 2'(4 - PIXELS_PER_CYCLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0][15:0] pix_q,   pix_d;    // latched pixels, [n] = pixel n
  logic [3:0][7:0]  gray_q,  gray_d;   // converted bytes, [n] = gray n
  logic [1:0]       idx_q,   idx_d;    // first pixel of the next group
  logic             accept;

  // ---------------------------------------------------------------------------
  // Converts one RGB565 pixel to gray. Each channel is widened to 8 bits by
  // replicating its top bits, so full scale maps to 255. The weights sum to
  // 256, which keeps S within 16 bits even after the +128 rounding term.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] to_gray(input logic [15:0] p);
    logic [7:0]  r8, g8, b8;
    logic [15:0] s;
    r8 = {p[15:11], p[15:13]};
    g8 = {p[10:5],  p[10:9]};
    b8 = {p[4:0],   p[4:2]};
    s  = 16'd54 * 16'(r8) + 16'd183 * 16'(g8) + 16'd19 * 16'(b8);
`ifdef GRAYSCALE_ROUND_EN
    s  = s + 16'd128;
`endif
    return s[15:8];
  endfunction

  assign accept = start && (iseId == customId);

  // ---------------------------------------------------------------------------
  // Next-state logic. DONE can accept a new instruction directly, so that
  // back-to-back issue costs no idle cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default value first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d = state_q;
    pix_d   = pix_q;
    idx_d   = idx_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_BUSY;
          pix_d   = {valueB, valueA};
          idx_d   = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        idx_d = idx_q + STEP;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Converter bank. The loop unrolls into PIXELS_PER_CYCLE converters. Each
  // converter picks its pixel relative to the current index.
  // ---------------------------------------------------------------------------
  always_comb begin
    gray_d = gray_q;
    if (state_q == ST_BUSY) begin
      for (int j = 0; j < PIXELS_PER_CYCLE; j++) begin
        gray_d[idx_q + 2'(j)] = to_gray(pix_q[idx_q + 2'(j)]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers.
  // ---------------------------------------------------------------------------
  // NOTE: the operand and gray storage is only a few flops, not a memory.
  // Clearing it on reset costs almost nothing and keeps the state after reset
  // fully defined.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      gray_q  <= '0;
      idx_q   <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge values and the order of these statements does not matter.
      state_q <= state_d;
      pix_q   <= pix_d;
      gray_q  <= gray_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded straight from the registered state.
  // ---------------------------------------------------------------------------
  assign busy   = (state_q == ST_BUSY);
  assign done   = (state_q == ST_DONE);
  assign result = done ? gray_q : 32'd0;

endmodule

// File: tb/tb_rgb565_grayscale_multi_ise.sv
// -----------------------------------------------------------------------------
// tb_rgb565_grayscale_multi_ise
//
// Directed bench for rgb565_grayscale_multi_ise. It builds one instance for
// each legal PIXELS_PER_CYCLE (1, 2, 4). All instances share clock, reset,
// iseId and the operands. Each instance has its own start, so only the unit
// under test sees an instruction. Expected bytes are worked out by hand for
// the pixels used:
//   0x0000 -> 0x00, 0xFFFF -> 0xFF, 0x07E0 -> 0xB6,
//   0xF800 -> 0x35 (0x36 rounded), 0x001F -> 0x12 (0x13 rounded).
// -----------------------------------------------------------------------------
module tb_rgb565_grayscale_multi_ise;

  logic        clock = 1'b0;
  logic        reset;
  logic        start1, start2, start4;
  logic [7:0]  iseId;
  logic [31:0] valueA, valueB;

  logic        done1, done2, done4;
  logic        busy1, busy2, busy4;
  logic [31:0] result1, result2, result4;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [7:0] G_G = 8'hB6;
`ifdef GRAYSCALE_ROUND_EN
  localparam logic [7:0] G_R = 8'h36;
  localparam logic [7:0] G_B = 8'h13;
`else
  localparam logic [7:0] G_R = 8'h35;
  localparam logic [7:0] G_B = 8'h12;
`endif

  always #5 clock = ~clock;

  rgb565_grayscale_multi_ise #(.customId(8'hC), .PIXELS_PER_CYCLE(1)) u_p1 (
    .clock(clock), .reset(reset), .start(start1), .iseId(iseId),
    .valueA(valueA), .valueB(valueB),
    .done(done1), .result(result1), .busy(busy1)
  );

  rgb565_grayscale_multi_ise #(.customId(8'hC), .PIXELS_PER_CYCLE(2)) u_p2 (
    .clock(clock), .reset(reset), .start(start2), .iseId(iseId),
    .valueA(valueA), .valueB(valueB),
    .done(done2), .result(result2), .busy(busy2)
  );

  rgb565_grayscale_multi_ise #(.customId(8'hC), .PIXELS_PER_CYCLE(4)) u_p4 (
    .clock(clock), .reset(reset), .start(start4), .iseId(iseId),
    .valueA(valueA), .valueB(valueB),
    .done(done4), .result(result4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to 1 ns after the next rising edge. Outputs are stable there and
  // inputs can be changed safely.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] cont_a [9];
  logic [31:0] cont_b [9];
  logic [31:0] cont_exp [3];

  initial begin
    reset  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    start4 = 1'b0;
    iseId  = 8'h00;
    valueA = '0;
    valueB = '0;

    // ---- reset state --------------------------------------------------------
    step();
    step();
    check("rst_done_p1", 32'(done1), 32'd0);
    check("rst_busy_p1", 32'(busy1), 32'd0);
    check("rst_result_p1", result1, 32'd0);
    check("rst_done_p2", 32'(done2), 32'd0);
    check("rst_result_p4", result4, 32'd0);
    reset = 1'b1;
    step();

    // ---- P=4: single-cycle conversion --------------------------------------
    iseId  = 8'hC;
    valueA = 32'h07E0_F800;
    valueB = 32'h0000_001F;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    check("p4_pre_done", 32'(done4), 32'd0);
    check("p4_pre_result", result4, 32'd0);
    valueA = 32'hFFFF_FFFF;   // later operand changes must not leak in
    valueB = 32'hFFFF_FFFF;
    step();
    check("p4_done", 32'(done4), 32'd1);
    check("p4_result", result4, {8'h00, G_B, G_G, G_R});
    check("p4_busy_in_done", 32'(busy4), 32'd0);
    step();
    check("p4_done_after", 32'(done4), 32'd0);
    check("p4_result_after", result4, 32'd0);
    check("p2_untouched", 32'(busy2 | done2), 32'd0);

    // ---- P=1: all-white pixels, four BUSY cycles ---------------------------
    valueA = 32'hFFFF_FFFF;
    valueB = 32'hFFFF_FFFF;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("p1_busy_%0d", k), 32'(busy1), 32'd1);
      check($sformatf("p1_nodone_%0d", k), 32'(done1), 32'd0);
      check($sformatf("p1_zero_result_%0d", k), result1, 32'd0);
      if (k < 3) step();
    end
    step();
    check("p1_done", 32'(done1), 32'd1);
    check("p1_result", result1, 32'hFFFF_FFFF);
    check("p1_busy_in_done", 32'(busy1), 32'd0);
    step();
    check("p1_done_after", 32'(done1), 32'd0);
    check("p1_result_after", result1, 32'd0);

    // ---- P=2: non-matching ID, then matching ID with zero pixels -----------
    iseId  = 8'hB;
    valueA = 32'hFFFF_FFFF;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    check("p2_badid_busy", 32'(busy2), 32'd0);
    check("p2_badid_done", 32'(done2), 32'd0);
    step();
    check("p2_badid_done2", 32'(done2), 32'd0);
    iseId  = 8'hC;
    valueA = 32'h0000_0000;
    valueB = 32'h0000_0000;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    check("p2_zero_busy0", 32'(busy2), 32'd1);
    step();
    check("p2_zero_busy1", 32'(busy2), 32'd1);
    check("p2_zero_nodone", 32'(done2), 32'd0);
    step();
    check("p2_zero_done", 32'(done2), 32'd1);
    check("p2_zero_result", result2, 32'd0);
    step();
    check("p2_zero_done_after", 32'(done2), 32'd0);

    // ---- P=1: reset during BUSY --------------------------------------------
    valueA = 32'hFFFF_FFFF;
    valueB = 32'hFFFF_FFFF;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    step();
    check("abort_busy_before", 32'(busy1), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_done", 32'(done1), 32'd0);
    check("abort_result", result1, 32'd0);
    step();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("abort_nodone_%0d", k), 32'(done1), 32'd0);
    end

    // ---- P=2: start held high, operands change every cycle -----------------
    // Instructions are accepted at cycles 0, 3 and 6 only. The filler
    // operands in between would change the result if they were latched.
    for (int k = 0; k < 9; k++) begin
      cont_a[k] = 32'hFFFF_FFFF;
      cont_b[k] = 32'hFFFF_FFFF;
    end
    cont_a[0] = 32'hF800_07E0;  cont_b[0] = 32'h001F_FFFF;
    cont_a[3] = 32'h0000_001F;  cont_b[3] = 32'h07E0_F800;
    cont_a[6] = 32'hFFFF_0000;  cont_b[6] = 32'h0000_07E0;
    cont_exp[0] = {G_B, 8'hFF, G_R, G_G};
    cont_exp[1] = {G_G, G_R, 8'h00, G_B};
    cont_exp[2] = {8'h00, G_G, 8'hFF, 8'h00};

    iseId  = 8'hC;
    start2 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      valueA = cont_a[k];
      valueB = cont_b[k];
      step();
      if (k % 3 == 2) begin
        check($sformatf("cont_done_%0d", k), 32'(done2), 32'd1);
        check($sformatf("cont_result_%0d", k), result2, cont_exp[k / 3]);
      end else begin
        check($sformatf("cont_busy_%0d", k), 32'(busy2), 32'd1);
        check($sformatf("cont_result_zero_%0d", k), result2, 32'd0);
      end
    end
    start2 = 1'b0;
    step();
    check("cont_idle_busy", 32'(busy2), 32'd0);
    check("cont_idle_done", 32'(done2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
